// File: rtl/tea_pkg.sv
// Shared TEA constants, FSM encoding and key slicing used by the encrypt and decrypt cores.
package tea_pkg;

   localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;
   localparam logic [31:0] TEA_SUM32 = 32'hC6EF3720;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } tea_state_e;

   // k0 lives in the top word of the 128-bit key, k3 in the bottom word.
   localparam int K0_MSB = 127;
   localparam int K1_MSB = 95;
   localparam int K2_MSB = 63;
   localparam int K3_MSB = 31;

   function automatic logic [31:0] key_word(input logic [127:0] key, input logic [1:0] idx);
      logic [31:0] w;
      case (idx)
         2'd0:    w = key[K0_MSB -: 32];
         2'd1:    w = key[K1_MSB -: 32];
         2'd2:    w = key[K2_MSB -: 32];
         2'd3:    w = key[K3_MSB -: 32];
         default: w = 32'd0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/tea_enc_round.sv
// One full TEA encryption cycle (both Feistel half-rounds), purely combinational.
module tea_enc_round
   import tea_pkg::*;
#(
   parameter logic [31:0] DELTA = TEA_DELTA
) (
   input  logic [31:0] i_v0,
   input  logic [31:0] i_v1,
   input  logic [31:0] i_sum,
   input  logic [31:0] i_k0,
   input  logic [31:0] i_k1,
   input  logic [31:0] i_k2,
   input  logic [31:0] i_k3,
   output logic [31:0] o_v0,
   output logic [31:0] o_v1,
   output logic [31:0] o_sum
);

   logic [31:0] w_sum;
   logic [31:0] w_v0;

   assign w_sum = i_sum + DELTA;
   assign w_v0  = i_v0 + (((i_v1 << 5'd4) + i_k0) ^ (i_v1 + w_sum) ^ ((i_v1 >> 5'd5) + i_k1));
   // Second half-round consumes the freshly updated v0.
   assign o_v1  = i_v1 + (((w_v0 << 5'd4) + i_k2) ^ (w_v0 + w_sum) ^ ((w_v0 >> 5'd5) + i_k3));
   assign o_v0  = w_v0;
   assign o_sum = w_sum;

endmodule

// File: rtl/tea_encrypt_core.sv
// Iterative TEA encryptor, one cycle per clock, valid/ready on both sides.
// Optional TEA_ENC_ROUND_CNT_EN adds a round_cnt progress output.
module tea_encrypt_core
   import tea_pkg::*;
#(
   parameter int          ROUNDS = 32,
   parameter logic [31:0] DELTA  = TEA_DELTA
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [63:0]   pt,
   input  logic [127:0]  key,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [63:0]   ct,
   output logic          busy
`ifdef TEA_ENC_ROUND_CNT_EN
   ,
   output logic [5:0]    round_cnt
`endif
);

   localparam logic [5:0] RND_LAST = 6'(ROUNDS - 1);

   tea_state_e  r_state;
   logic [31:0] r_v0, r_v1, r_sum;
   logic [31:0] r_k0, r_k1, r_k2, r_k3;
   logic [5:0]  r_rnd;
   logic [63:0] r_ct;
   logic        r_in_ready, r_out_valid, r_busy;

   logic [31:0] w_v0, w_v1, w_sum;

   tea_enc_round #(.DELTA(DELTA)) u_round (
      .i_v0  (r_v0),
      .i_v1  (r_v1),
      .i_sum (r_sum),
      .i_k0  (r_k0),
      .i_k1  (r_k1),
      .i_k2  (r_k2),
      .i_k3  (r_k3),
      .o_v0  (w_v0),
      .o_v1  (w_v1),
      .o_sum (w_sum)
   );

   // Control FSM plus datapath registers; handshake outputs are registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_v0        <= 32'd0;
         r_v1        <= 32'd0;
         r_sum       <= 32'd0;
         r_k0        <= 32'd0;
         r_k1        <= 32'd0;
         r_k2        <= 32'd0;
         r_k3        <= 32'd0;
         r_rnd       <= 6'd0;
         r_ct        <= 64'd0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_v0       <= pt[63:32];
                  r_v1       <= pt[31:0];
                  r_k0       <= key_word(key, 2'd0);
                  r_k1       <= key_word(key, 2'd1);
                  r_k2       <= key_word(key, 2'd2);
                  r_k3       <= key_word(key, 2'd3);
                  r_sum      <= 32'd0;
                  r_rnd      <= 6'd0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_v0  <= w_v0;
               r_v1  <= w_v1;
               r_sum <= w_sum;
               r_rnd <= r_rnd + 6'd1;
               if (r_rnd == RND_LAST) begin
                  r_ct        <= {w_v0, w_v1};
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_rnd       <= 6'd0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
               r_rnd       <= 6'd0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign ct        = r_ct;
   assign busy      = r_busy;
`ifdef TEA_ENC_ROUND_CNT_EN
   assign round_cnt = r_rnd;
`endif

endmodule

// File: tb/tb_tea_encrypt_core.sv
// Scoreboard bench for tea_encrypt_core using directed TEA vectors.
module tb_tea_encrypt_core;

   localparam int ROUNDS = 32;
   localparam logic [63:0]  GOLD_PT  = 64'h12345678_9ABCDEF0;
   localparam logic [127:0] GOLD_KEY = 128'h11111111_22222222_33333333_44444444;
   localparam logic [63:0]  GOLD_CT  = 64'h5CF85E83_E967E1FD;
   localparam logic [63:0]  ZERO_CT  = 64'h41EA3A0A_94BAA940;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [63:0]  pt = 64'd0;
   logic [127:0] key = 128'd0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [63:0]  ct;
   logic         busy;
`ifdef TEA_ENC_ROUND_CNT_EN
   logic [5:0]   round_cnt;
`endif

   typedef struct {
      logic [63:0] ct;
      int          t_acc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   logic prev_ov = 1'b0;

   tea_encrypt_core #(.ROUNDS(ROUNDS)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pt        (pt),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ct        (ct),
      .busy      (busy)
`ifdef TEA_ENC_ROUND_CNT_EN
      ,
      .round_cnt (round_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every rising out_valid pops one expected block and checks data and latency.
   always @(negedge clk) begin
      if (!reset && out_valid && !prev_ov) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got ct %h with empty scoreboard", ct);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_ct", ct, e.ct);
            chk("sb_latency", 64'(cyc - e.t_acc), 64'(ROUNDS));
         end
      end
      prev_ov = reset ? 1'b0 : out_valid;
   end

   task automatic send(input logic [63:0] p, input logic [127:0] k, input logic [63:0] e,
                       input bit push, input bit keep, output int t);
      @(negedge clk);
      pt = p;
      key = k;
      in_valid = 1'b1;
      t = -1;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) begin
            @(posedge clk);
            #1;
            t = cyc;
            break;
         end
         @(negedge clk);
      end
      if (!keep) in_valid = 1'b0;
      if (t < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
      end else if (push) begin
         sb.push_back('{ct: e, t_acc: t});
      end
   endtask

   task automatic wait_out();
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL out_timeout: got out_valid=0 expected 1 within 200 cycles");
      end
   endtask

   initial begin
      int t1, t2, td;
      logic [63:0] held;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ct", ct, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Golden vector, consumer always ready
      out_ready = 1'b1;
      send(GOLD_PT, GOLD_KEY, GOLD_CT, 1'b1, 1'b0, t1);
      @(negedge clk);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_in_ready", 64'(in_ready), 64'd0);
      wait_out();
      chk("final_sum", 64'(dut.r_sum), 64'(32'hC6EF3720));
`ifdef TEA_ENC_ROUND_CNT_EN
      chk("rcnt_done", 64'(round_cnt), 64'(ROUNDS));
`endif
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
`ifdef TEA_ENC_ROUND_CNT_EN
      chk("rcnt_idle", 64'(round_cnt), 64'd0);
`endif

      // Zero vector
      send(64'd0, 128'd0, ZERO_CT, 1'b1, 1'b0, t1);
      wait_out();
      @(negedge clk);

      // Backpressure: stall 10 cycles, then one-cycle out_ready pulse
      out_ready = 1'b0;
      send(GOLD_PT, GOLD_KEY, GOLD_CT, 1'b1, 1'b0, t1);
      wait_out();
      held = ct;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         chk("bp_ct_stable", ct, GOLD_CT);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      chk("bp_ct_held", ct, held);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      chk("bp_release_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;

      // Input churn: in_valid held, pt/key changed during RUN
      send(GOLD_PT, GOLD_KEY, GOLD_CT, 1'b1, 1'b1, t1);
      send(64'd0, 128'd0, ZERO_CT, 1'b1, 1'b0, t2);
      td = t2 - t1;
      chk("churn_spacing", 64'(td), 64'(ROUNDS + 2));
      wait_out();
      @(negedge clk);

      // Reset in the middle of a block
      send(GOLD_PT, GOLD_KEY, GOLD_CT, 1'b0, 1'b0, t1);
      repeat (15) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_ct", ct, 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      send(GOLD_PT, GOLD_KEY, GOLD_CT, 1'b1, 1'b0, t1);
      wait_out();
      @(negedge clk);

      // Drain check
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tea_encrypt_core.md
Name: tea_encrypt_core

Overview:
Iterative TEA encryption engine: one Feistel cycle (both half-rounds) per clock, 64-bit block, 128-bit key.
- Sits directly upstream of the decryption stage and produces the ciphertext that stage consumes.
- Valid/ready handshake on both sides, so it can be fed from a host/UART loader and drained into the decryptor or a result checker.
- Final sum after 32 rounds is 32'hC6EF3720, which is the decryptor's starting sum.

Parameters:
- ROUNDS, 32, number of TEA cycles per block; legal range 1..63.
- DELTA, 32'h9E3779B9, key-schedule constant added to sum each round.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  engine can accept a block
- pt  in  64  plaintext; v0=pt[63:32], v1=pt[31:0]
- key  in  128  k0=key[127:96], k1=key[95:64], k2=key[63:32], k3=key[31:0]
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- ct  out  64  ciphertext; v0=ct[63:32], v1=ct[31:0]
- busy  out  1  high in RUN state

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, ct=0, internal v0/v1/sum/round counter=0, key regs=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, capture pt into v0/v1 and key into k0..k3; sum=0; rnd=0; go to RUN.
  - RUN: in_ready=0, busy=1. Each clock computes:
    - s' = sum + DELTA
    - v0' = v0 + (((v1<<4)+k0) ^ (v1+s') ^ ((v1>>5)+k1))
    - v1' = v1 + (((v0'<<4)+k2) ^ (v0'+s') ^ ((v0'>>5)+k3)), using the updated v0'
    - Register v0', v1', s'; rnd++.
    - When rnd==ROUNDS-1 on this edge, go to DONE, load ct={v0',v1'}, and set out_valid=1.
  - DONE: out_valid=1, ct held stable. On out_ready, clear out_valid and go to IDLE. in_ready=0 while in DONE.
- Arithmetic: all arithmetic is mod 2^32 unsigned; shifts are logical. rnd is 6 bits.
- Latency and throughput:
  - Accept on edge t; out_valid first seen high after edge t+ROUNDS.
  - Minimum spacing between accepted blocks is ROUNDS+2 cycles, because there is no accept while in DONE.
- Input stability: pt and key are sampled only at the accept edge. Changes while in RUN or DONE are ignored.
- Backpressure: out_ready held low keeps the engine in DONE indefinitely. ct and out_valid must not change while stalled.
- Simultaneous events: in_valid high while in RUN or DONE has no effect, because in_ready=0. out_ready high while out_valid=0 is ignored.
- Reset mid-operation (RUN or DONE): return immediately to IDLE. The block in flight is discarded, out_valid=0, ct=0.
- ROUNDS=1 boundary: RUN lasts exactly one cycle.

Optional Feature:
- Macro TEA_ENC_ROUND_CNT_EN.
- Defined: adds output port round_cnt[5:0], which mirrors rnd. It counts 1..ROUNDS during RUN, holds ROUNDS in DONE, and is 0 in IDLE and after reset. Intended for LED/progress display.
- Not defined: the port is absent and the core is otherwise identical.

Decomposition:
- Shared package tea_pkg holds:
  - TEA_DELTA (32'h9E3779B9)
  - TEA_SUM32 (32'hC6EF3720)
  - the state encoding (IDLE/RUN/DONE, 2 bits)
  - the key-word slicing constants
- tea_pkg is also used by the decryptor.
- Natural sub-module: tea_enc_round. It is purely combinational; inputs v0, v1, sum, k0..k3; outputs v0', v1', s'. It is instantiated once, with the core holding all registers.

Test Plan:
- Golden vector: pt=64'h12345678_9ABCDEF0, key=128'h11111111_22222222_33333333_44444444, ROUNDS=32 -> out_valid after 32 cycles, ct=64'h5CF85E83_E967E1FD, internal sum=32'hC6EF3720.
- Zero vector: pt=0, key=0 -> ct=64'h41EA3A0A_94BAA940.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> ct stable, in_ready=0 throughout. Then pulse out_ready -> in_ready=1 the next cycle.
- Input churn: change pt/key and hold in_valid=1 during RUN -> result still equals the golden vector for the originally captured block. The second block is accepted only after returning to IDLE.
- Reset at round 15: -> out_valid=0, ct=0, in_ready=1 immediately. A following golden-vector block produces the correct ct.
- TEA_ENC_ROUND_CNT_EN defined: round_cnt steps 1..32 during RUN, holds 32 in DONE, returns to 0 in IDLE.
